// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiplier, restoring divider, valid/ready.
// Define MDU_FAST_MUL_EN to compute multiplies with a single registered product (cycle-1 result).
module mdu_iterative #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [SEL_W-1:0] SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             KILL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [SEL_W-1:0] SelMul    = SEL_W'(11);
  localparam logic [SEL_W-1:0] SelMulh   = SEL_W'(12);
  localparam logic [SEL_W-1:0] SelMulhsu = SEL_W'(13);
  localparam logic [SEL_W-1:0] SelMulhu  = SEL_W'(14);
  localparam logic [SEL_W-1:0] SelDiv    = SEL_W'(15);
  localparam logic [SEL_W-1:0] SelDivu   = SEL_W'(16);
  localparam logic [SEL_W-1:0] SelRem    = SEL_W'(17);
  localparam logic [SEL_W-1:0] SelRemu   = SEL_W'(18);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
  typedef enum logic [1:0] {KindMulLo, KindMulHi, KindDiv, KindRem} kind_e;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  result_q, result_d;

  // Request decode
  logic              dec_legal, dec_s1, dec_s2, dec_neg, dec_special;
  kind_e             dec_kind;
  logic              neg1, neg2;
  logic [WIDTH-1:0]  mag1, mag2, special_res;

  always_comb begin
    dec_legal = 1'b1;
    dec_kind  = KindMulLo;
    dec_s1    = 1'b0;
    dec_s2    = 1'b0;
    unique case (SELECT)
      SelMul:    begin dec_kind = KindMulLo; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      SelMulh:   begin dec_kind = KindMulHi; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      SelMulhsu: begin dec_kind = KindMulHi; dec_s1 = 1'b1; end
      SelMulhu:  dec_kind = KindMulHi;
      SelDiv:    begin dec_kind = KindDiv; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      SelDivu:   dec_kind = KindDiv;
      SelRem:    begin dec_kind = KindRem; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      SelRemu:   dec_kind = KindRem;
      default:   dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    neg1 = dec_s1 & DATA1[WIDTH-1];
    neg2 = dec_s2 & DATA2[WIDTH-1];
    mag1 = neg1 ? -DATA1 : DATA1;
    mag2 = neg2 ? -DATA2 : DATA2;
    // The remainder follows the dividend; everything else follows the operand sign product.
    dec_neg = (dec_kind == KindRem) ? neg1 : (neg1 ^ neg2);

    dec_special = 1'b0;
    special_res = '0;
    if (dec_kind == KindDiv || dec_kind == KindRem) begin
      if (DATA2 == '0) begin
        dec_special = 1'b1;
        special_res = (dec_kind == KindDiv) ? '1 : DATA1;
      end else if (dec_s1 && DATA1 == {1'b1, {(WIDTH-1){1'b0}}} && DATA2 == '1) begin
        dec_special = 1'b1;
        special_res = (dec_kind == KindDiv) ? DATA1 : '0;
      end
    end
  end

`ifdef MDU_FAST_MUL_EN
  // Low 2*WIDTH bits of the sign-extended product are exact for every signedness mix.
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
  logic [WIDTH-1:0]   fast_res;

  always_comb begin
    fast_a    = {{WIDTH{neg1}}, DATA1};
    fast_b    = {{WIDTH{neg2}}, DATA2};
    fast_prod = fast_a * fast_b;
    fast_res  = (dec_kind == KindMulLo) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
  end
`endif

  // One iteration of each datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [WIDTH:0]     div_trial, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi, div_lo;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   final_res;
  logic               is_mul_q;

  assign is_mul_q = (kind_q == KindMulLo) || (kind_q == KindMulHi);

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};

    div_trial = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    div_ge    = ~div_diff[WIDTH];
    div_hi    = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ge};

    prod_s    = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
    final_res = '0;
    unique case (kind_q)
      KindMulLo: final_res = prod_s[WIDTH-1:0];
      KindMulHi: final_res = prod_s[2*WIDTH-1:WIDTH];
      KindDiv:   final_res = neg_q ? -div_lo : div_lo;
      KindRem:   final_res = neg_q ? -div_hi : div_hi;
      default:   final_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (IN_VALID && !KILL) begin
          kind_d = dec_kind;
          neg_d  = dec_neg;
          cnt_d  = '0;
          hi_d   = '0;
          if (dec_kind == KindMulLo || dec_kind == KindMulHi) begin
            lo_d   = mag2;
            opnd_d = mag1;
          end else begin
            lo_d   = mag1;
            opnd_d = mag2;
          end
          if (!dec_legal) begin
            result_d = '0;
            state_d  = StDone;
          end else if (dec_special) begin
            result_d = special_res;
            state_d  = StDone;
`ifdef MDU_FAST_MUL_EN
          end else if (dec_kind == KindMulLo || dec_kind == KindMulHi) begin
            result_d = fast_res;
            state_d  = StDone;
`endif
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (KILL) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          hi_d  = is_mul_q ? mul_hi : div_hi;
          lo_d  = is_mul_q ? mul_lo : div_lo;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH-1)) begin
            result_d = final_res;
            cnt_d    = '0;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        if (KILL || OUT_READY) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      kind_q   <= KindMulLo;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  assign IN_READY  = (state_q == StIdle);
  assign OUT_VALID = (state_q == StDone);
  assign BUSY      = (state_q == StCalc) || (state_q == StDone);
  assign RESULT    = result_q;

endmodule
